// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared encodings for the machine-mode CSR file and trap controller
package csr_pkg;

   typedef enum logic [2:0] {
      OP_NONE   = 3'd0,
      OP_CSRRW  = 3'd1,
      OP_CSRRS  = 3'd2,
      OP_CSRRC  = 3'd3,
      OP_ECALL  = 3'd4,
      OP_EBREAK = 3'd5,
      OP_MRET   = 3'd6
   } csr_op_e;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;

   localparam logic [31:0] MCAUSE_ECALL  = 32'd11;
   localparam logic [31:0] MCAUSE_BREAK  = 32'd3;
   localparam logic [31:0] MCAUSE_MTI    = 32'h8000_0007;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MTIE     = 7;
   localparam int MIP_MTIP     = 7;

   function automatic logic is_csr_op(input csr_op_e op);
      return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with increment enable and independent half writes
module csr_counter64 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        inc_i,
   input  logic        wr_lo_i,
   input  logic        wr_hi_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] count_o
);

   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;
   logic        carry;

   // A write to the low half swallows the carry that would have rippled up this cycle.
   always_comb begin
      carry = inc_i && (lo_q == 32'hFFFF_FFFF) && !wr_lo_i;
      lo_d  = wr_lo_i ? wdata_i : lo_q + {31'd0, inc_i};
      hi_d  = wr_hi_i ? wdata_i : hi_q + {31'd0, carry};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lo_q <= 32'd0;
         hi_q <= 32'd0;
      end else begin
         lo_q <= lo_d;
         hi_q <= hi_d;
      end
   end

   assign count_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file, trap sequencer and IFU redirect source
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter int          XLEN           = 32,
   parameter logic [31:0] MVENDORID      = 32'h7973_7978,
   parameter logic [31:0] MARCHID        = 32'h016f_e3b8,
   parameter int          HAS_COUNTERS   = 1,
   parameter int          MTVEC_VECTORED = 1
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_valid,
   input  logic [2:0]      i_op,
   input  logic [11:0]     i_csr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic            i_wskip,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_next_pc,
   input  logic            i_retire,
   input  logic            i_mtip,
   output logic [XLEN-1:0] o_rdata,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_upc,
   output logic            o_illegal
);

   logic        mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d;
   logic [29:0] base_q, base_d;
   logic        mode_q, mode_d;
   logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
   logic [63:0] mcycle, minstret;

   csr_op_e     op;
   logic        valid_c, csr_op, wr_attempt, implemented, read_only, csr_we;
   logic        sync_trap, mret_go, irq_take;
   logic [31:0] wval, vec_base;

   assign op       = csr_op_e'(i_op);
   assign valid_c  = i_valid && !i_reset;
   assign vec_base = {base_q, 2'b00};

   always_comb begin
      o_rdata     = 32'd0;
      implemented = 1'b1;
      read_only   = 1'b0;
      case (i_csr)
         CSR_MSTATUS:   o_rdata = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
         CSR_MIE:       o_rdata = {24'd0, mtie_q, 7'd0};
         CSR_MTVEC:     o_rdata = {base_q, 1'b0, mode_q};
         CSR_MSCRATCH:  o_rdata = mscratch_q;
         CSR_MEPC:      o_rdata = mepc_q;
         CSR_MCAUSE:    o_rdata = mcause_q;
         CSR_MTVAL:     o_rdata = mtval_q;
         CSR_MIP:       o_rdata = {24'd0, i_mtip, 7'd0};
         CSR_MCYCLE:    o_rdata = mcycle[31:0];
         CSR_MCYCLEH:   o_rdata = mcycle[63:32];
         CSR_MINSTRET:  o_rdata = minstret[31:0];
         CSR_MINSTRETH: o_rdata = minstret[63:32];
         CSR_MVENDORID: begin o_rdata = MVENDORID; read_only = 1'b1; end
         CSR_MARCHID:   begin o_rdata = MARCHID;   read_only = 1'b1; end
         default:       implemented = 1'b0;
      endcase
   end

   assign csr_op     = is_csr_op(op);
   assign wr_attempt = csr_op && !i_wskip;
   assign o_illegal  = csr_op && (!implemented || (read_only && wr_attempt));
   assign csr_we     = valid_c && wr_attempt && !o_illegal;

   always_comb begin
      case (op)
         OP_CSRRS: wval = o_rdata | i_wdata;
         OP_CSRRC: wval = o_rdata & ~i_wdata;
         default:  wval = i_wdata;
      endcase
   end

   assign sync_trap = valid_c && ((op == OP_ECALL) || (op == OP_EBREAK));
   assign mret_go   = valid_c && (op == OP_MRET);
   assign irq_take  = valid_c && mie_q && mtie_q && i_mtip &&
                      (csr_op || (op == OP_NONE) || (op == OP_MRET));

   assign o_redirect = sync_trap || mret_go || irq_take;

   always_comb begin
      if (irq_take)       o_upc = mode_q ? vec_base + 32'd28 : vec_base;
      else if (sync_trap) o_upc = vec_base;
      else                o_upc = mepc_q;
   end

   // Applied in commit order: CSR write, MRET, then trap entry overwrites what it owns.
   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtie_d     = mtie_q;
      base_d     = base_q;
      mode_d     = mode_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      if (csr_we) begin
         case (i_csr)
            CSR_MSTATUS: begin
               mie_d  = wval[MSTATUS_MIE];
               mpie_d = wval[MSTATUS_MPIE];
            end
            CSR_MIE:      mtie_d = wval[MIE_MTIE];
            CSR_MTVEC: begin
               base_d = wval[31:2];
               mode_d = (MTVEC_VECTORED != 0) && (wval[1:0] == 2'b01);
            end
            CSR_MSCRATCH: mscratch_d = wval;
            CSR_MEPC:     mepc_d     = wval & ~32'd3;
            CSR_MCAUSE:   mcause_d   = wval;
            CSR_MTVAL:    mtval_d    = wval;
            default: ;
         endcase
      end
      if (mret_go) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end
      if (sync_trap) begin
         mepc_d   = i_pc & ~32'd3;
         mcause_d = (op == OP_ECALL) ? MCAUSE_ECALL : MCAUSE_BREAK;
         mtval_d  = 32'd0;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end
      if (irq_take) begin
         mepc_d   = (op == OP_MRET) ? mepc_q : (i_next_pc & ~32'd3);
         mcause_d = MCAUSE_MTI;
         mpie_d   = mie_d;
         mie_d    = 1'b0;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtie_q     <= 1'b0;
         base_q     <= 30'd0;
         mode_q     <= 1'b0;
         mscratch_q <= 32'd0;
         mepc_q     <= 32'd0;
         mcause_q   <= 32'd0;
         mtval_q    <= 32'd0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtie_q     <= mtie_d;
         base_q     <= base_d;
         mode_q     <= mode_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
      end
   end

   generate
      if (HAS_COUNTERS != 0) begin : g_counters
         csr_counter64 u_mcycle (
            .clk_i   (i_clock),
            .rst_i   (i_reset),
            .inc_i   (1'b1),
            .wr_lo_i (csr_we && (i_csr == CSR_MCYCLE)),
            .wr_hi_i (csr_we && (i_csr == CSR_MCYCLEH)),
            .wdata_i (wval),
            .count_o (mcycle)
         );
         csr_counter64 u_minstret (
            .clk_i   (i_clock),
            .rst_i   (i_reset),
            .inc_i   (i_retire),
            .wr_lo_i (csr_we && (i_csr == CSR_MINSTRET)),
            .wr_hi_i (csr_we && (i_csr == CSR_MINSTRETH)),
            .wdata_i (wval),
            .count_o (minstret)
         );
      end else begin : g_no_counters
         assign mcycle   = 64'd0;
         assign minstret = 64'd0;
      end
   endgenerate

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - scoreboard bench for csr_trap_unit with directed vectors
module tb_csr_trap_unit;

   localparam logic [2:0] NONE = 3'd0, RW = 3'd1, RS = 3'd2, RC = 3'd3;
   localparam logic [2:0] ECALL = 3'd4, EBREAK = 3'd5, MRET = 3'd6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [11:0] csr = 12'd0;
   logic [31:0] wdata = 32'd0;
   logic        wskip = 1'b0;
   logic [31:0] pc = 32'd0;
   logic [31:0] npc = 32'd0;
   logic        retire = 1'b0;
   logic        mtip = 1'b0;
   logic [31:0] rdata, upc;
   logic        redirect, illegal;

   typedef struct {
      string       nm;
      logic        chk;
      logic [31:0] rd;
      logic        redir;
      logic [31:0] upc;
      logic        ill;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   csr_trap_unit dut (
      .i_clock    (clk),
      .i_reset    (rst),
      .i_valid    (valid),
      .i_op       (op),
      .i_csr      (csr),
      .i_wdata    (wdata),
      .i_wskip    (wskip),
      .i_pc       (pc),
      .i_next_pc  (npc),
      .i_retire   (retire),
      .i_mtip     (mtip),
      .o_rdata    (rdata),
      .o_redirect (redirect),
      .o_upc      (upc),
      .o_illegal  (illegal)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s actual=%08h required=%08h", nm, field, act, exp);
      end
   endtask

   // Monitor: every committed cycle is matched against the oldest queued expectation.
   always @(negedge clk) begin
      if (valid) begin
         if (q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_output actual=valid required=no_output");
         end else begin
            exp_t e;
            e = q.pop_front();
            cmp(e.nm, "redirect", {31'd0, redirect}, {31'd0, e.redir});
            cmp(e.nm, "illegal", {31'd0, illegal}, {31'd0, e.ill});
            if (e.redir) cmp(e.nm, "upc", upc, e.upc);
            if (e.chk) cmp(e.nm, "rdata", rdata, e.rd);
         end
      end
   end

   task automatic issue(input string nm, input logic [2:0] o, input logic [11:0] a,
                        input logic [31:0] wd, input logic sk, input logic [31:0] p,
                        input logic [31:0] np, input logic ret, input logic tip,
                        input logic chk, input logic [31:0] rd, input logic redir,
                        input logic [31:0] eupc, input logic ill);
      exp_t e;
      @(posedge clk);
      #1;
      valid = 1'b1; op = o; csr = a; wdata = wd; wskip = sk;
      pc = p; npc = np; retire = ret; mtip = tip;
      e.nm = nm; e.chk = chk; e.rd = rd; e.redir = redir; e.upc = eupc; e.ill = ill;
      q.push_back(e);
   endtask

   task automatic rd_csr(input string nm, input logic [11:0] a, input logic [31:0] exp);
      issue(nm, RS, a, 32'd0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, exp, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic wr_csr(input string nm, input logic [2:0] o, input logic [11:0] a,
                         input logic [31:0] wd, input logic chk, input logic [31:0] exp);
      issue(nm, o, a, wd, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, chk, exp, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      valid = 1'b0; op = NONE; csr = 12'd0; wdata = 32'd0; wskip = 1'b0;
      retire = 1'b0; mtip = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // mscratch read-modify-write
      wr_csr("mscratch_rw", RW, 12'h340, 32'hDEADBEEF, 1'b1, 32'd0);
      wr_csr("mscratch_rs", RS, 12'h340, 32'h1, 1'b1, 32'hDEADBEEF);
      rd_csr("mscratch_rd", 12'h340, 32'hDEADBEEF);
      rd_csr("mstatus_reset", 12'h300, 32'h0000_1800);

      // ECALL then MRET
      wr_csr("mtvec_wr", RW, 12'h305, 32'h8000_1000, 1'b1, 32'd0);
      wr_csr("mstatus_set_mie", RS, 12'h300, 32'h8, 1'b1, 32'h0000_1800);
      issue("ecall", ECALL, 12'h000, 32'd0, 1'b0, 32'h8000_0100, 32'h8000_0104,
            1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h8000_1000, 1'b0);
      rd_csr("ecall_mepc", 12'h341, 32'h8000_0100);
      rd_csr("ecall_mcause", 12'h342, 32'd11);
      rd_csr("ecall_mstatus", 12'h300, 32'h0000_1880);
      issue("mret", MRET, 12'h000, 32'd0, 1'b0, 32'h8000_1010, 32'h8000_1014,
            1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h8000_0100, 1'b0);
      rd_csr("mret_mstatus", 12'h300, 32'h0000_1888);

      // timer interrupt alongside a CSR write, vectored mtvec
      wr_csr("mtvec_vec", RW, 12'h305, 32'h8000_1001, 1'b1, 32'h8000_1000);
      wr_csr("mie_mtie", RS, 12'h304, 32'h80, 1'b1, 32'd0);
      issue("irq_csrrw", RW, 12'h340, 32'd5, 1'b0, 32'h8000_0200, 32'h8000_0204,
            1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'h8000_101C, 1'b0);
      rd_csr("irq_mscratch", 12'h340, 32'd5);
      rd_csr("irq_mepc", 12'h341, 32'h8000_0204);
      rd_csr("irq_mcause", 12'h342, 32'h8000_0007);
      rd_csr("irq_mstatus", 12'h300, 32'h0000_1880);
      issue("mip_mtip", RS, 12'h344, 32'd0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1,
            1'b1, 32'h80, 1'b0, 32'd0, 1'b0);
      rd_csr("mtvec_rd", 12'h305, 32'h8000_1001);

      // minstret counts retire pulses; each read sees the pre-increment value
      wr_csr("minstreth_clr", RW, 12'hB82, 32'd0, 1'b0, 32'd0);
      wr_csr("minstret_clr", RW, 12'hB02, 32'd0, 1'b0, 32'd0);
      for (int k = 0; k < 10; k++)
         issue("minstret_run", RS, 12'hB02, 32'd0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0,
               1'b1, 32'(k), 1'b0, 32'd0, 1'b0);
      rd_csr("minstret_10", 12'hB02, 32'd10);
      rd_csr("minstreth_0", 12'hB82, 32'd0);

      // mcycle 64-bit wrap
      wr_csr("mcycleh_max", RW, 12'hB80, 32'hFFFF_FFFF, 1'b0, 32'd0);
      wr_csr("mcycle_max", RW, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'd0);
      rd_csr("mcycleh_pre", 12'hB80, 32'hFFFF_FFFF);
      rd_csr("mcycle_wrap", 12'hB00, 32'd0);
      rd_csr("mcycleh_wrap", 12'hB80, 32'd0);

      // illegal accesses
      issue("unimpl_7c0", RS, 12'h7C0, 32'd0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0,
            1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      issue("ro_write_f11", RW, 12'hF11, 32'h1234_5678, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
            1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      issue("illegal_mscratch_w", RC, 12'h7C0, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
            1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      rd_csr("mvendorid", 12'hF11, 32'h7973_7978);
      rd_csr("marchid", 12'hF12, 32'h016F_E3B8);
      rd_csr("mscratch_kept", 12'h340, 32'd5);

      // reset in the middle of an ECALL cycle
      issue("rst_ecall", ECALL, 12'h000, 32'd0, 1'b0, 32'h8000_0300, 32'h8000_0304,
            1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      #2 rst = 1'b1;
      idle();
      rst = 1'b0;
      rd_csr("rst_mstatus", 12'h300, 32'h0000_1800);
      rd_csr("rst_mscratch", 12'h340, 32'd0);
      rd_csr("rst_mepc", 12'h341, 32'd0);
      rd_csr("rst_mcause", 12'h342, 32'd0);
      rd_csr("rst_mtvec", 12'h305, 32'd0);
      rd_csr("rst_mie", 12'h304, 32'd0);
      idle();

      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL scoreboard_drain actual=%0d_pending required=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
